// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: watches the signal-controller lamp outputs for
// conflicting greens, illegal phase sequencing and short yellows, latches the
// first fault and drives a flashing-red output while faulted.
// Build macro MON_WATCHDOG_EN enables the per-phase dwell watchdog (code 6).
module traffic_conflict_monitor #(
  parameter int unsigned MIN_YELLOW = 5,
  parameter int unsigned MAX_DWELL  = 200,
  parameter int unsigned FLASH_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       n_left_green,
  input  logic       s_left_green,
  input  logic       e_left_green,
  input  logic       w_left_green,
  input  logic       ns_green,
  input  logic       ew_green,
  input  logic       ns_yellow,
  input  logic       ew_yellow,
  input  logic       ns_red,
  input  logic       ew_red,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] phase,
  output logic [7:0] cycle_cnt,
  output logic       flash_out
);

  localparam int unsigned LAMP_W  = 10;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DIV_W   = 8;

  // Bit positions inside the sampled lamp vector
  localparam int unsigned L_NL  = 9;
  localparam int unsigned L_SL  = 8;
  localparam int unsigned L_NSG = 7;
  localparam int unsigned L_NSY = 6;
  localparam int unsigned L_EL  = 5;
  localparam int unsigned L_WL  = 4;
  localparam int unsigned L_EWG = 3;
  localparam int unsigned L_EWY = 2;
  localparam int unsigned L_NSR = 1;
  localparam int unsigned L_EWR = 0;

  localparam logic [CODE_W-1:0] C_NONE    = CODE_W'(0);
  localparam logic [CODE_W-1:0] C_CROSS   = CODE_W'(1);
  localparam logic [CODE_W-1:0] C_RED_GO  = CODE_W'(2);
  localparam logic [CODE_W-1:0] C_DARK    = CODE_W'(3);
  localparam logic [CODE_W-1:0] C_ILLEGAL = CODE_W'(4);
  localparam logic [CODE_W-1:0] C_SHORT_Y = CODE_W'(5);
  localparam logic [CODE_W-1:0] C_WDOG    = CODE_W'(6);

  localparam logic [DWELL_W-1:0] WDOG_LIMIT = DWELL_W'(MAX_DWELL - 1);
  localparam logic [DIV_W-1:0]   FLASH_LAST = DIV_W'(FLASH_DIV - 1);

`ifdef MON_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    PH_SYNC    = 4'd0,
    PH_NL      = 4'd1,
    PH_SL      = 4'd2,
    PH_NSG     = 4'd3,
    PH_NSY     = 4'd4,
    PH_EL      = 4'd5,
    PH_WL      = 4'd6,
    PH_EWG     = 4'd7,
    PH_EWY     = 4'd8,
    PH_ALLRED  = 4'd9,
    PH_INVALID = 4'd15
  } phase_e;

  // Next phase in the fixed controller ring
  function automatic phase_e succ(input phase_e p);
    case (p)
      PH_NL:   succ = PH_SL;
      PH_SL:   succ = PH_NSG;
      PH_NSG:  succ = PH_NSY;
      PH_NSY:  succ = PH_EL;
      PH_EL:   succ = PH_WL;
      PH_WL:   succ = PH_EWG;
      PH_EWG:  succ = PH_EWY;
      PH_EWY:  succ = PH_NL;
      default: succ = PH_INVALID;
    endcase
  endfunction

  function automatic logic is_named(input phase_e p);
    is_named = (p >= PH_NL) && (p <= PH_EWY);
  endfunction

  logic [LAMP_W-1:0]  lamp_c, lamp_q;
  logic               vld_q;
  phase_e             phase_q, phase_d, last_q, last_d, dec_c;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               first_q, first_d;
  logic               fault_q, fault_d;
  logic [CODE_W-1:0]  code_q, code_d, conf_c, cause_c;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               flash_q, flash_d;
  logic [DIV_W-1:0]   fdiv_q, fdiv_d;
  logic               ns_go_c, ew_go_c, one_go_c, legal_c;

  assign lamp_c = {n_left_green, s_left_green, ns_green, ns_yellow,
                   e_left_green, w_left_green, ew_green, ew_yellow,
                   ns_red, ew_red};

  // Decode the sampled lamps into a phase and a conflict code
  always_comb begin
    ns_go_c  = lamp_q[L_NL] | lamp_q[L_SL] | lamp_q[L_NSG] | lamp_q[L_NSY];
    ew_go_c  = lamp_q[L_EL] | lamp_q[L_WL] | lamp_q[L_EWG] | lamp_q[L_EWY];
    one_go_c = $onehot(lamp_q[L_NL:L_EWY]);
    dec_c    = PH_INVALID;
    if (one_go_c && ns_go_c && lamp_q[L_EWR]) begin
      if      (lamp_q[L_NL])  dec_c = PH_NL;
      else if (lamp_q[L_SL])  dec_c = PH_SL;
      else if (lamp_q[L_NSG]) dec_c = PH_NSG;
      else                    dec_c = PH_NSY;
    end else if (one_go_c && ew_go_c && lamp_q[L_NSR]) begin
      if      (lamp_q[L_EL])  dec_c = PH_EL;
      else if (lamp_q[L_WL])  dec_c = PH_WL;
      else if (lamp_q[L_EWG]) dec_c = PH_EWG;
      else                    dec_c = PH_EWY;
    end else if (!ns_go_c && !ew_go_c && lamp_q[L_NSR] && lamp_q[L_EWR]) begin
      dec_c = PH_ALLRED;
    end

    conf_c = C_NONE;
    if (ns_go_c && ew_go_c) begin
      conf_c = C_CROSS;
    end else if ((lamp_q[L_NSR] && ns_go_c) || (lamp_q[L_EWR] && ew_go_c)) begin
      conf_c = C_RED_GO;
    end else if ((!lamp_q[L_NSR] && !ns_go_c) || (!lamp_q[L_EWR] && !ew_go_c)) begin
      conf_c = C_DARK;
    end
  end

  // Phase tracking, fault latching and flash generation
  always_comb begin
    phase_d = phase_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    first_d = first_q;
    fault_d = fault_q;
    code_d  = code_q;
    cyc_d   = cyc_q;
    flash_d = flash_q;
    fdiv_d  = fdiv_q;
    cause_c = C_NONE;
    legal_c = 1'b1;

    if (vld_q) begin
      if (fault_q) begin
        if (clr_fault && (conf_c == C_NONE)) begin
          phase_d = PH_SYNC;
          last_d  = PH_SYNC;
          dwell_d = '0;
          first_d = 1'b0;
          fault_d = 1'b0;
          code_d  = C_NONE;
          flash_d = 1'b0;
          fdiv_d  = '0;
        end else if (fdiv_q == FLASH_LAST) begin
          flash_d = ~flash_q;
          fdiv_d  = '0;
        end else begin
          fdiv_d = fdiv_q + DIV_W'(1);
        end
      end else begin
        cause_c = conf_c;
        if (phase_q == PH_SYNC) begin
          // First named phase after sync is taken on trust
          if (is_named(dec_c)) begin
            phase_d = dec_c;
            dwell_d = '0;
            first_d = 1'b1;
          end
        end else if (dec_c == phase_q) begin
          if (dwell_q != {DWELL_W{1'b1}}) dwell_d = dwell_q + DWELL_W'(1);
          if (WDOG_EN && (dwell_d == WDOG_LIMIT) && (cause_c == C_NONE)) cause_c = C_WDOG;
        end else begin
          if (phase_q == PH_ALLRED) legal_c = (dec_c == PH_ALLRED) || (dec_c == succ(last_q));
          else                      legal_c = (dec_c == PH_ALLRED) || (dec_c == succ(phase_q));
          if (!legal_c && (cause_c == C_NONE)) cause_c = C_ILLEGAL;
          // dwell_q counts the cycles held beyond the entry cycle
          if (((phase_q == PH_NSY) || (phase_q == PH_EWY)) && !first_q &&
              (({1'b0, dwell_q} + 9'd1) < 9'(MIN_YELLOW)) && (cause_c == C_NONE))
            cause_c = C_SHORT_Y;
          if ((phase_q == PH_EWY) && (dec_c == PH_NL)) cyc_d = cyc_q + CNT_W'(1);
          phase_d = dec_c;
          dwell_d = '0;
          first_d = 1'b0;
        end
        if (is_named(phase_d)) last_d = phase_d;
        if (cause_c != C_NONE) begin
          fault_d = 1'b1;
          code_d  = cause_c;
          flash_d = 1'b1;
          fdiv_d  = '0;
        end
      end
    end
  end

  // State registers, including the lamp sample stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_q  <= '0;
      vld_q   <= 1'b0;
      phase_q <= PH_SYNC;
      last_q  <= PH_SYNC;
      dwell_q <= '0;
      first_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= C_NONE;
      cyc_q   <= '0;
      flash_q <= 1'b0;
      fdiv_q  <= '0;
    end else begin
      lamp_q  <= lamp_c;
      vld_q   <= 1'b1;
      phase_q <= phase_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      first_q <= first_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      cyc_q   <= cyc_d;
      flash_q <= flash_d;
      fdiv_q  <= fdiv_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign phase      = phase_q;
  assign cycle_cnt  = cyc_q;
  assign flash_out  = flash_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed scenarios plus random lamp
// traffic, every cycle compared against a behavioural model of the monitor.
module tb_traffic_conflict_monitor;

  localparam int MIN_YELLOW = 5;
  localparam int MAX_DWELL  = 200;
  localparam int FLASH_DIV  = 4;

  logic       clk, rst_n, clr;
  logic [9:0] lamps;
  logic       fault, flash_out;
  logic [2:0] fault_code;
  logic [3:0] phase;
  logic [7:0] cycle_cnt;
  logic [16:0] act;

  int pass_cnt, total_cnt;

  // model state
  logic [9:0] m_samp;
  bit m_vld, m_fault, m_first, m_flash;
  int m_phase, m_last, m_held, m_code, m_cycles, m_fcnt;

  traffic_conflict_monitor #(.MIN_YELLOW(MIN_YELLOW), .MAX_DWELL(MAX_DWELL), .FLASH_DIV(FLASH_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .n_left_green(lamps[9]), .s_left_green(lamps[8]), .e_left_green(lamps[5]), .w_left_green(lamps[4]),
    .ns_green(lamps[7]), .ew_green(lamps[3]), .ns_yellow(lamps[6]), .ew_yellow(lamps[2]),
    .ns_red(lamps[1]), .ew_red(lamps[0]), .clr_fault(clr),
    .fault(fault), .fault_code(fault_code), .phase(phase), .cycle_cnt(cycle_cnt), .flash_out(flash_out)
  );

  assign act = {fault, fault_code, phase, cycle_cnt, flash_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lamp pattern showing phase p cleanly (1..8 named, 9 all-red)
  function automatic logic [9:0] lamp_of(input int p);
    logic [9:0] v;
    v = '0;
    if (p >= 1 && p <= 8) begin
      v[10-p] = 1'b1;
      if (p <= 4) v[0] = 1'b1; else v[1] = 1'b1;
    end else if (p == 9) begin
      v[1:0] = 2'b11;
    end
    return v;
  endfunction

  function automatic int m_decode(input logic [9:0] v);
    logic [7:0] g;
    int p;
    g = v[9:2];
    p = 0;
    if ($countones(g) == 1) begin
      for (int i = 0; i < 8; i++) if (g[i]) p = 8 - i;
      if (p <= 4 && v[0]) return p;
      if (p >= 5 && v[1]) return p;
      return 15;
    end
    if (g == 8'h00 && v[1:0] == 2'b11) return 9;
    return 15;
  endfunction

  function automatic logic [16:0] exp_vec();
    return {m_fault, 3'(m_code), 4'(m_phase), 8'(m_cycles), m_flash};
  endfunction

  task automatic model_reset();
    m_samp = '0; m_vld = 0; m_fault = 0; m_first = 0; m_flash = 0;
    m_phase = 0; m_last = 0; m_held = 0; m_code = 0; m_cycles = 0; m_fcnt = 0;
  endtask

  // One rising edge of the monitor as the rules describe it
  task automatic model_edge(input logic [9:0] v, input bit c);
    int d, cause;
    bit ns_go, ew_go, ns_r, ew_r, legal;
    if (!m_vld) begin
      m_vld = 1; m_samp = v;
      return;
    end
    ns_go = |m_samp[9:6]; ew_go = |m_samp[5:2];
    ns_r = m_samp[1]; ew_r = m_samp[0];
    cause = 0;
    if (ns_go && ew_go) cause = 1;
    else if ((ns_r && ns_go) || (ew_r && ew_go)) cause = 2;
    else if ((!ns_r && !ns_go) || (!ew_r && !ew_go)) cause = 3;
    d = m_decode(m_samp);
    if (m_fault) begin
      if (c && cause == 0) begin
        m_fault = 0; m_code = 0; m_phase = 0; m_last = 0; m_held = 0;
        m_first = 0; m_flash = 0; m_fcnt = 0;
      end else begin
        m_fcnt++;
        if (m_fcnt == FLASH_DIV) begin m_flash = !m_flash; m_fcnt = 0; end
      end
    end else begin
      if (m_phase == 0) begin
        if (d >= 1 && d <= 8) begin m_phase = d; m_first = 1; m_held = 1; end
      end else if (d == m_phase) begin
        m_held++;
`ifdef MON_WATCHDOG_EN
        if (cause == 0 && m_held >= MAX_DWELL) cause = 6;
`endif
      end else begin
        if (m_phase == 9) legal = (d == 9) || (d == m_last % 8 + 1);
        else legal = (d == 9) || (d == m_phase % 8 + 1);
        if (cause == 0 && !legal) cause = 4;
        if (cause == 0 && (m_phase == 4 || m_phase == 8) && !m_first && m_held < MIN_YELLOW) cause = 5;
        if (m_phase == 8 && d == 1) m_cycles = (m_cycles + 1) % 256;
        m_phase = d; m_held = 1; m_first = 0;
      end
      if (m_phase >= 1 && m_phase <= 8) m_last = m_phase;
      if (cause != 0) begin m_fault = 1; m_code = cause; m_flash = 1; m_fcnt = 0; end
    end
    m_samp = v;
  endtask

  // Drive one cycle of lamps/clear, advance model, settle for sampling
  task automatic step(input logic [9:0] v, input bit c);
    @(negedge clk);
    lamps = v; clr = c;
    @(posedge clk);
    model_edge(v, c);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; lamps = 10'h3FF;
    model_reset();
    #12;
    total_cnt++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault); else pass_cnt++;
    total_cnt++; if (fault_code !== 3'd0) $display("FAIL reset_code: got %0d expected 0", fault_code); else pass_cnt++;
    total_cnt++; if (phase !== 4'd0) $display("FAIL reset_phase: got %0d expected 0", phase); else pass_cnt++;
    total_cnt++; if (cycle_cnt !== 8'd0) $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt); else pass_cnt++;
    total_cnt++; if (flash_out !== 1'b0) $display("FAIL reset_flash: got %b expected 0", flash_out); else pass_cnt++;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_legal_cycle();
    int sp[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 1};
    int sn[9] = '{15, 15, 25, 5, 15, 15, 25, 5, 3};
    apply_reset();
    for (int s = 0; s < 9; s++) begin
      for (int k = 0; k < sn[s]; k++) begin
        step(lamp_of(sp[s]), 1'b0);
        total_cnt++;
        if (act !== exp_vec()) $display("FAIL legal_cycle seg %0d cyc %0d: got %h expected %h", s, k, act, exp_vec());
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (fault !== 1'b0 || cycle_cnt !== 8'd1)
      $display("FAIL legal_cycle_end: got fault=%b cycle_cnt=%0d expected fault=0 cycle_cnt=1", fault, cycle_cnt);
    else pass_cnt++;
  endtask

  task automatic test_conflict_and_clear();
    logic [9:0] conf;
    conf = lamp_of(3) | 10'b0000001000;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      step(lamp_of(k < 2 ? 1 : (k < 4 ? 2 : 3)), 1'b0);
      total_cnt++;
      if (act !== exp_vec()) $display("FAIL conflict_lead cyc %0d: got %h expected %h", k, act, exp_vec());
      else pass_cnt++;
    end
    step(conf, 1'b0);
    total_cnt++;
    if (fault !== 1'b0) $display("FAIL conflict_latency: got fault=%b expected 0 one edge after sample", fault);
    else pass_cnt++;
    step(lamp_of(3), 1'b0);
    total_cnt++;
    if (fault !== 1'b1 || fault_code !== 3'd1 || flash_out !== 1'b1)
      $display("FAIL conflict_raise: got fault=%b code=%0d flash=%b expected 1/1/1", fault, fault_code, flash_out);
    else pass_cnt++;
    for (int i = 1; i < 16; i++) begin
      step(lamp_of(3), 1'b0);
      total_cnt++;
      if (flash_out !== (((i / 4) % 2) == 0) || act !== exp_vec())
        $display("FAIL conflict_flash cyc %0d: got %h expected %h", i, act, exp_vec());
      else pass_cnt++;
    end
    step(conf, 1'b0);
    step(conf, 1'b1);
    total_cnt++;
    if (fault !== 1'b1 || fault_code !== 3'd1)
      $display("FAIL clear_blocked: got fault=%b code=%0d expected 1/1", fault, fault_code);
    else pass_cnt++;
    step(lamp_of(3), 1'b0);
    step(lamp_of(3), 1'b1);
    total_cnt++;
    if (fault !== 1'b0 || phase !== 4'd0 || fault_code !== 3'd0 || flash_out !== 1'b0)
      $display("FAIL clear_ok: got fault=%b phase=%0d code=%0d flash=%b expected 0/0/0/0", fault, phase, fault_code, flash_out);
    else pass_cnt++;
  endtask

  task automatic test_sequence_errors();
    int sp[4] = '{1, 2, 3, 5};
    int sn[4] = '{2, 2, 3, 2};
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < sn[s]; k++) begin
        step(lamp_of(sp[s]), 1'b0);
        total_cnt++;
        if (act !== exp_vec()) $display("FAIL skip_yellow seg %0d cyc %0d: got %h expected %h", s, k, act, exp_vec());
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (fault !== 1'b1 || fault_code !== 3'd4)
      $display("FAIL skip_yellow_code: got fault=%b code=%0d expected 1/4", fault, fault_code);
    else pass_cnt++;
    step(lamp_of(3), 1'b0);
    step(lamp_of(3), 1'b1);
    sp = '{3, 3, 4, 5};
    sn = '{1, 2, 3, 2};
    for (int s = 1; s < 4; s++) begin
      for (int k = 0; k < sn[s]; k++) begin
        step(lamp_of(sp[s]), 1'b0);
        total_cnt++;
        if (act !== exp_vec()) $display("FAIL short_yellow seg %0d cyc %0d: got %h expected %h", s, k, act, exp_vec());
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (fault !== 1'b1 || fault_code !== 3'd5)
      $display("FAIL short_yellow_code: got fault=%b code=%0d expected 1/5", fault, fault_code);
    else pass_cnt++;
  endtask

  task automatic test_watchdog();
    logic [3:0] exp_code;
    logic       exp_fault;
`ifdef MON_WATCHDOG_EN
    exp_fault = 1'b1; exp_code = 4'd6;
`else
    exp_fault = 1'b0; exp_code = 4'd0;
`endif
    apply_reset();
    for (int k = 0; k < 209; k++) begin
      step(lamp_of(k < 2 ? 5 : (k < 4 ? 6 : 7)), 1'b0);
      total_cnt++;
      if (act !== exp_vec()) $display("FAIL watchdog cyc %0d: got %h expected %h", k, act, exp_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (fault !== exp_fault || {1'b0, fault_code} !== exp_code)
      $display("FAIL watchdog_end: got fault=%b code=%0d expected %b/%0d", fault, fault_code, exp_fault, exp_code);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fault();
    int sp[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    apply_reset();
    for (int s = 0; s < 8; s++)
      for (int k = 0; k < 5; k++) step(lamp_of(sp[s]), 1'b0);
    step(lamp_of(8) | 10'b0010000000, 1'b0);
    step(lamp_of(8), 1'b0);
    step(lamp_of(8), 1'b0);
    total_cnt++;
    if (fault !== 1'b1 || act !== exp_vec())
      $display("FAIL mid_fault_latched: got %h expected %h", act, exp_vec());
    else pass_cnt++;
    rst_n = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (act !== 17'd0) $display("FAIL async_reset: got %h expected 00000", act);
    else pass_cnt++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(lamp_of(5), 1'b0);
      total_cnt++;
      if (act !== exp_vec()) $display("FAIL resume_el cyc %0d: got %h expected %h", k, act, exp_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (fault !== 1'b0 || phase !== 4'd5)
      $display("FAIL resume_el_end: got fault=%b phase=%0d expected 0/5", fault, phase);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int cur, r, n, p;
    logic [9:0] v;
    apply_reset();
    cur = 8;
    for (int seg = 0; seg < 320; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        v = 10'($urandom); n = 1;
      end else if (r < 14) begin
        p = $urandom_range(1, 9); v = lamp_of(p); n = $urandom_range(1, 6);
        if (p <= 8) cur = p;
      end else if (r < 22) begin
        v = lamp_of(9); n = $urandom_range(1, 4);
      end else begin
        cur = cur % 8 + 1; v = lamp_of(cur); n = $urandom_range(2, 9);
      end
      for (int k = 0; k < n; k++) begin
        step(v, $urandom_range(0, 15) == 0);
        total_cnt++;
        if (act !== exp_vec()) $display("FAIL random seg %0d cyc %0d: got %h expected %h", seg, k, act, exp_vec());
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    test_reset();
    test_legal_cycle();
    test_conflict_and_clear();
    test_sequence_errors();
    test_watchdog();
    test_reset_mid_fault();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter MIN_YELLOW, 5, minimum legal yellow dwell in clock cycles (1..254).
REQ-002 Parameter MAX_DWELL, 200, watchdog limit in cycles for any one phase (2..254).
REQ-003 Parameter FLASH_DIV, 4, half-period in cycles of flash_out while faulted (1..255).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 n_left_green, s_left_green, e_left_green, w_left_green  in  1 each  left-turn green lamps from the signal controller.
REQ-007 ns_green, ew_green, ns_yellow, ew_yellow, ns_red, ew_red  in  1 each  through-movement lamps from the signal controller.
REQ-008 clr_fault  in  1  single-cycle request to clear the latched fault.
REQ-009 fault  out  1  latched fault indication.
REQ-010 fault_code  out  3  first fault cause: 0 none, 1 cross-axis conflict, 2 red+go same axis, 3 dark axis, 4 illegal transition, 5 short yellow, 6 watchdog.
REQ-011 phase  out  4  decoded phase: 0 SYNC, 1 NL, 2 SL, 3 NSG, 4 NSY, 5 EL, 6 WL, 7 EWG, 8 EWY, 9 ALLRED, 15 INVALID.
REQ-012 cycle_cnt  out  8  count of completed full cycles (EWY->NL transitions), wraps 255->0.
REQ-013 flash_out  out  1  flashing-red drive, toggles while fault=1, 0 otherwise.

Function
REQ-014 All ten lamp inputs SHALL be registered once (sample stage); all decode uses the sampled copy only.
REQ-015 Decode: NS-go = n_left_green|s_left_green|ns_green|ns_yellow; EW-go likewise for e/w/ew; a phase is decoded only when exactly one go lamp is on and the opposite-axis red is on; no go lamp and both reds on = ALLRED; anything else = INVALID.
REQ-016 phase, fault, fault_code SHALL update on the edge after the sample edge (2-cycle latency input -> output).
REQ-017 Code 1 when NS-go and EW-go both 1; code 2 when an axis has its red and any of its go lamps on; code 3 when an axis has neither red nor any go lamp.
REQ-018 Legal transitions: self; NL->SL->NSG->NSY->EL->WL->EWG->EWY->NL; any named phase->ALLRED; ALLRED->successor of the last non-ALLRED phase. Any other change of decoded phase = code 4.
REQ-019 After reset or clear, state is SYNC; first decoded NL..EWY phase is accepted unchecked for code 4/5; conflict codes 1-3 are checked in SYNC.
REQ-020 Dwell counter: 8-bit, cleared on each phase change, saturates at 255.
REQ-021 Leaving NSY or EWY with dwell < MIN_YELLOW (excluding yellow entered from SYNC) = code 5.
REQ-022 Dwell reaching MAX_DWELL in any phase other than SYNC = code 6.
REQ-023 First fault latches fault=1 and fault_code; later faults do not change fault_code; simultaneous causes resolve to the lowest code.
REQ-024 While fault=1, phase tracking freezes; cycle_cnt holds.
REQ-025 clr_fault clears fault, fault_code and returns to SYNC only if no code 1-3 condition is present in the same cycle; otherwise ignored.
REQ-026 clr_fault while fault=0 has no effect.
REQ-027 flash_out: starts 1 on the cycle fault rises, toggles every FLASH_DIV cycles, forced 0 when fault=0.

Reset
REQ-028 rst_n low SHALL asynchronously force: sample regs 0, phase 0 (SYNC), dwell 0, fault 0, fault_code 0, cycle_cnt 0, flash_out 0, flash divider 0.
REQ-029 Reset mid-fault or mid-phase SHALL discard all history; no fault reported for the first post-reset phase.

Configuration
REQ-030 Macro MON_WATCHDOG_EN: defined -> REQ-022 active; undefined -> code 6 never raised, dwell saturation still used for REQ-021, all other behaviour identical.

Verification
REQ-031 Legal sequence NL(15) SL(15) NSG(25) NSY(5) EL(15) WL(15) EWG(25) EWY(5) NL -> fault=0, cycle_cnt=1 after EWY->NL.
REQ-032 ns_green=1 and ew_green=1 for one cycle during NSG -> fault=1, fault_code=1 two edges later; flash_out toggles every 4 cycles.
REQ-033 NSG->EL directly (skip yellow) -> fault_code=4; NSY held 3 cycles then EL -> fault_code=5.
REQ-034 Hold EWG 200 cycles with MON_WATCHDOG_EN -> fault_code=6; without macro -> fault=0.
REQ-035 clr_fault with conflict present -> fault stays 1; clr_fault with clean lamps -> fault=0, phase=SYNC next edge.
REQ-036 rst_n low mid-EWY with fault latched -> all outputs 0 asynchronously; resume at EL -> no fault.
